// File: rtl/zipdma_pattern_master.sv
// rtl/zipdma_pattern_master.sv - Wishbone pipelined master that writes or reads back an LFSR pattern burst.
// Write pass issues LFSR words; read pass checks returned words against the same sequence.
module zipdma_pattern_master #(
  parameter int ADDRESS_WIDTH = 30,
  parameter int BUS_WIDTH     = 64,
  parameter int LGLEN         = 12,
  localparam int DW = BUS_WIDTH,
  localparam int AW = ADDRESS_WIDTH - $clog2(DW/8)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_ctl_cyc,
  input  logic            i_ctl_stb,
  input  logic            i_ctl_we,
  input  logic [1:0]      i_ctl_addr,
  input  logic [31:0]     i_ctl_data,
  input  logic [3:0]      i_ctl_sel,
  output logic            o_ctl_stall,
  output logic            o_ctl_ack,
  output logic [31:0]     o_ctl_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_busy,
  output logic            o_int
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     base, addr;
  logic [LGLEN-1:0]  len, issued, acked, miscount;
  logic [31:0]       seed;
  logic [DW-1:0]     issue_lfsr, check_lfsr;
  logic              dir, done, buserr, mismatch;
  logic              ctl_wr, start_req, abort_req, accept, ack_ok, last_ack;
  logic [31:0]       rd_mux;

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
    return {s[DW-2:0], s[DW-1] ^ s[DW-2]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign o_ctl_stall = 1'b0;
  assign o_wb_cyc    = (state == BUS);
  assign o_wb_stb    = (state == BUS) && (issued != len);
  assign o_wb_we     = dir;
  assign o_wb_addr   = addr;
  assign o_wb_data   = issue_lfsr;
  assign o_wb_sel    = '1;
  assign o_busy      = (state == BUS);

  always_comb begin
    state_next = state;
    ctl_wr     = i_ctl_stb && i_ctl_we;
    start_req  = ctl_wr && (i_ctl_addr == 2'd0) && i_ctl_sel[0] && i_ctl_data[0] && (state == IDLE);
    abort_req  = ctl_wr && (i_ctl_addr == 2'd0) && i_ctl_sel[0] && i_ctl_data[2] && (state == BUS);
    accept     = o_wb_stb && !i_wb_stall;
    // An error in the same cycle as an ack suppresses the ack.
    ack_ok     = (state == BUS) && i_wb_ack && !i_wb_err;
    last_ack   = ack_ok && (acked == len - 1'b1);
    case (state)
      IDLE:    if (start_req && (len != '0)) state_next = BUS;
      BUS:     if (i_wb_err || abort_req || last_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h0;
    case (i_ctl_addr)
      2'd0: rd_mux = {12'(miscount), 15'h0, done, buserr, mismatch, dir, o_busy};
      2'd1: rd_mux = 32'(base);
      2'd2: rd_mux = 32'(len);
      2'd3: rd_mux = seed;
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ctl_ack  <= 1'b0;
      o_ctl_data <= '0;
      o_int      <= 1'b0;
      base       <= '0;
      addr       <= '0;
      len        <= '0;
      issued     <= '0;
      acked      <= '0;
      miscount   <= '0;
      seed       <= '0;
      issue_lfsr <= '0;
      check_lfsr <= '0;
      dir        <= 1'b0;
      done       <= 1'b0;
      buserr     <= 1'b0;
      mismatch   <= 1'b0;
    end else begin
      o_ctl_ack <= i_ctl_stb;
      o_int     <= 1'b0;
      if (i_ctl_stb) o_ctl_data <= rd_mux;

      if (ctl_wr && (state == IDLE)) begin
        case (i_ctl_addr)
          2'd1: base <= AW'(merge(32'(base), i_ctl_data, i_ctl_sel));
          2'd2: len  <= LGLEN'(merge(32'(len), i_ctl_data, i_ctl_sel));
          2'd3: seed <= merge(seed, i_ctl_data, i_ctl_sel);
          default: ;
        endcase
      end

      if (start_req) begin
        dir        <= i_ctl_data[1];
        done       <= (len == '0);
        o_int      <= (len == '0);
        buserr     <= 1'b0;
        mismatch   <= 1'b0;
        miscount   <= '0;
        issue_lfsr <= DW'(seed) << (DW - 32);
        check_lfsr <= DW'(seed) << (DW - 32);
        issued     <= '0;
        acked      <= '0;
        addr       <= base;
      end

      if (state == BUS) begin
        if (accept) begin
          addr       <= addr + 1'b1;
          issued     <= issued + 1'b1;
          issue_lfsr <= lfsr_step(issue_lfsr);
        end
        if (ack_ok) begin
          acked <= acked + 1'b1;
          if (!dir) begin
            check_lfsr <= lfsr_step(check_lfsr);
            if (i_wb_data != check_lfsr) begin
              mismatch <= 1'b1;
              if (miscount != '1) miscount <= miscount + 1'b1;
            end
          end
        end
        if (i_wb_err) begin
          buserr <= 1'b1;
          o_int  <= 1'b1;
        end else if (abort_req) begin
          done  <= 1'b0;
          o_int <= 1'b1;
        end else if (last_ack) begin
          done  <= 1'b1;
          o_int <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_zipdma_pattern_master.sv
// tb/tb_zipdma_pattern_master.sv - randomized bench with memory slave model for zipdma_pattern_master.
module tb_zipdma_pattern_master;
  localparam int DW = 64;
  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_ctl_cyc = 0, i_ctl_stb = 0, i_ctl_we = 0;
  logic [1:0]    i_ctl_addr = 0;
  logic [31:0]   i_ctl_data = 0;
  logic [3:0]    i_ctl_sel = 0;
  logic          o_ctl_stall, o_ctl_ack;
  logic [31:0]   o_ctl_data;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic [7:0]    o_wb_sel;
  logic          i_wb_stall = 0, i_wb_ack = 0, i_wb_err = 0;
  logic [DW-1:0] i_wb_data = 0;
  logic          o_busy, o_int;

  zipdma_pattern_master #(.ADDRESS_WIDTH(30), .BUS_WIDTH(64), .LGLEN(12)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_ctl_cyc(i_ctl_cyc), .i_ctl_stb(i_ctl_stb), .i_ctl_we(i_ctl_we),
    .i_ctl_addr(i_ctl_addr), .i_ctl_data(i_ctl_data), .i_ctl_sel(i_ctl_sel),
    .o_ctl_stall(o_ctl_stall), .o_ctl_ack(o_ctl_ack), .o_ctl_data(o_ctl_data),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_busy(o_busy), .o_int(o_int)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model of the transfer currently configured
  logic [AW-1:0] m_base;
  int            m_len, err_at, corrupt_at;
  logic [31:0]   m_seed;
  bit            m_dir;
  int            acc_cnt, ack_cnt, exp_mis, int_count;
  bit            prev_int, chk_cyc_low, cyc_seen;
  logic [63:0]   mem [int unsigned];
  int unsigned   pend[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_n(input logic [31:0] sd, input int n);
    logic [63:0] s;
    s = {sd, 32'h0};
    for (int i = 0; i < n; i++) s = {s[62:0], s[63] ^ s[62]};
    return s;
  endfunction

  // Slave memory and per-cycle compare process
  initial begin
    int unsigned a;
    logic [63:0] d;
    forever begin
      @(negedge clk);
      if (!i_reset) begin
        check("busy_eq_cyc", o_busy, o_wb_cyc);
        if (chk_cyc_low) check("cyc_after_err", o_wb_cyc, 0);
        if (o_int) begin
          int_count++;
          if (prev_int) check("int_single_pulse", 1, 0);
        end
        prev_int = o_int;
        if (o_wb_cyc) cyc_seen = 1;
        if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
          check("req_addr", o_wb_addr, AW'(m_base + acc_cnt));
          check("req_we", o_wb_we, m_dir);
          check("req_sel", o_wb_sel, 8'hFF);
          check("req_within_len", acc_cnt < m_len, 1);
          if (m_dir) check("req_data", o_wb_data, lfsr_n(m_seed, acc_cnt));
          if (o_wb_we) mem[o_wb_addr] = o_wb_data;
          pend.push_back(o_wb_addr);
          acc_cnt++;
        end
      end
      @(posedge clk); #1;
      chk_cyc_low = i_wb_err;
      i_wb_ack = 0;
      i_wb_err = 0;
      if (!o_wb_cyc) pend.delete();
      i_wb_stall = ($urandom_range(3) == 0);
      if (o_wb_cyc && pend.size() > 0 && $urandom_range(2) != 0) begin
        a = pend.pop_front();
        ack_cnt++;
        d = mem.exists(a) ? mem[a] : 64'h0;
        if (ack_cnt == corrupt_at) d = 64'h0;
        i_wb_ack = 1;
        if (ack_cnt == err_at) begin
          i_wb_err  = 1;
          i_wb_data = ~lfsr_n(m_seed, ack_cnt - 1);
        end else begin
          i_wb_data = d;
          if (!m_dir && d !== lfsr_n(m_seed, ack_cnt - 1)) exp_mis++;
        end
      end
    end
  end

  task automatic ctl_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(posedge clk); #1;
    i_ctl_cyc = 1; i_ctl_stb = 1; i_ctl_we = 1; i_ctl_addr = a; i_ctl_data = d; i_ctl_sel = s;
    @(posedge clk); #1;
    i_ctl_cyc = 0; i_ctl_stb = 0; i_ctl_we = 0;
    check("ctl_wr_ack", o_ctl_ack, 1);
  endtask

  task automatic ctl_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    i_ctl_cyc = 1; i_ctl_stb = 1; i_ctl_we = 0; i_ctl_addr = a; i_ctl_sel = 4'hF;
    @(posedge clk); #1;
    i_ctl_cyc = 0; i_ctl_stb = 0;
    check("ctl_rd_ack", o_ctl_ack, 1);
    d = o_ctl_data;
  endtask

  task automatic start_cfg(input bit dir, input logic [AW-1:0] base, input int len,
                           input logic [31:0] seed, input int e_at, input int c_at);
    ctl_write(2'd1, 32'(base));
    ctl_write(2'd2, 32'(len));
    ctl_write(2'd3, seed);
    m_base = base; m_len = len; m_seed = seed; m_dir = dir;
    err_at = e_at; corrupt_at = c_at;
    acc_cnt = 0; ack_cnt = 0; exp_mis = 0; cyc_seen = 0;
    ctl_write(2'd0, {29'h0, 1'b0, dir, 1'b1});
  endtask

  task automatic run(input bit dir, input logic [AW-1:0] base, input int len, input logic [31:0] seed,
                     input int e_at, input int c_at, output logic [31:0] st);
    int n0, t;
    bit err;
    n0 = int_count;
    start_cfg(dir, base, len, seed, e_at, c_at);
    if (len > 0) check("cyc_after_start", o_wb_cyc, 1);
    t = 0;
    while (int_count == n0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (int_count == n0) check("completion_timeout", 0, 1);
    repeat (4) @(posedge clk);
    check("int_count", int_count, n0 + 1);
    err = (e_at != 0) && (e_at <= len);
    if (!err) check("issued_count", acc_cnt, len);
    ctl_read(2'd0, st);
    check("status", st, {12'(exp_mis), 15'h0, !err, err, exp_mis != 0, dir, 1'b0});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] st, rd;
    int n0;
    logic [AW-1:0] b;
    int l;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_int", o_int, 0);
    check("rst_ack", o_ctl_ack, 0);
    i_reset = 0;
    ctl_read(2'd0, rd); check("rst_status", rd, 32'h0);
    ctl_read(2'd1, rd); check("rst_base", rd, 32'h0);
    ctl_read(2'd3, rd); check("rst_seed", rd, 32'h0);

    ctl_write(2'd1, 32'h0000_0ABC);
    ctl_write(2'd1, 32'hFFFF_FF12, 4'b0001);
    ctl_read(2'd1, rd); check("base_bytesel", rd, 32'h0000_0A12);

    check("lfsr_pin1", lfsr_n(32'h12345678, 1), 64'h2468ACF0_00000000);
    check("lfsr_pin2", lfsr_n(32'h12345678, 2), 64'h48D159E0_00000000);

    run(1, 27'h100, 3, 32'h12345678, 0, 0, st);
    check("mem0", mem[32'h100], 64'h12345678_00000000);
    check("mem1", mem[32'h101], 64'h2468ACF0_00000000);
    check("mem2", mem[32'h102], 64'h48D159E0_00000000);
    check("write_status_lit", st, 32'h0000_0012);

    run(0, 27'h100, 3, 32'h12345678, 0, 0, st);
    check("read_status_lit", st, 32'h0000_0010);

    run(0, 27'h100, 3, 32'h12345678, 0, 2, st);
    check("corrupt_status_lit", st, 32'h0010_0014);

    run(1, 27'h200, 8, 32'hCAFEF00D, 4, 0, st);
    check("err_status_lit", st, 32'h0000_000A);

    // Zero-length start: completes with the control ack and never touches the bus
    n0 = int_count;
    ctl_write(2'd2, 32'h0);
    cyc_seen = 0;
    ctl_write(2'd0, 32'h3);
    check("len0_int", o_int, 1);
    repeat (5) @(posedge clk);
    check("len0_no_cyc", cyc_seen, 0);
    check("len0_int_count", int_count, n0 + 1);
    ctl_read(2'd0, rd); check("len0_status", rd, 32'h0000_0012);

    // Abort mid-burst, config writes ignored while busy, then restart with a fresh seed
    start_cfg(1, 27'h300, 100, 32'hA5A5_0001, 0, 0);
    repeat (10) @(posedge clk);
    ctl_write(2'd1, 32'h999);
    repeat (3) @(posedge clk);
    ctl_write(2'd0, 32'h4);
    check("abort_cyc_low", o_wb_cyc, 0);
    check("abort_int", o_int, 1);
    ctl_read(2'd0, rd); check("abort_status", rd, 32'h0000_0002);
    ctl_read(2'd1, rd); check("base_ignored_busy", rd, 32'h300);
    run(1, 27'h300, 5, 32'h0BAD_BEEF, 0, 0, st);

    // Reset mid-transfer: bus released, no completion interrupt
    start_cfg(1, 27'h400, 50, 32'h1111_2222, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    n0 = int_count;
    i_reset = 1;
    @(posedge clk); #1;
    check("reset_mid_cyc", o_wb_cyc, 0);
    i_reset = 0;
    repeat (5) @(posedge clk);
    check("reset_mid_no_int", int_count, n0);
    ctl_read(2'd0, rd); check("reset_mid_status", rd, 32'h0);

    // Randomized write/read pass pairs, some wrapping the address space
    for (int it = 0; it < 10; it++) begin
      l = $urandom_range(24, 1);
      b = ($urandom_range(1) == 0) ? AW'((1 << AW) - $urandom_range(4, 1)) : AW'($urandom);
      n0 = $urandom;
      run(1, b, l, n0, ($urandom_range(3) == 0) ? $urandom_range(l, 1) : 0, 0, st);
      run(0, b, l, n0, ($urandom_range(4) == 0) ? $urandom_range(l, 1) : 0,
          ($urandom_range(1) == 0) ? $urandom_range(l, 1) : 0, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
